// File: rtl/alu_pkg.sv
// Shared encodings for the ALU execution engine: status codes, opcodes,
// instruction field positions and the controller state encoding.
package alu_pkg;

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_EXEC  = 2'b01;
   localparam logic [1:0] ST_DONE  = 2'b10;
   localparam logic [1:0] ST_FAULT = 2'b11;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_AND = 4'h3;
   localparam logic [3:0] OP_OR  = 4'h4;
   localparam logic [3:0] OP_XOR = 4'h5;
   localparam logic [3:0] OP_NOT = 4'h6;
   localparam logic [3:0] OP_SLL = 4'h7;
   localparam logic [3:0] OP_SRL = 4'h8;
   localparam logic [3:0] OP_SRA = 4'h9;
   localparam logic [3:0] OP_MUL = 4'hA;

   localparam int OPC_LSB = 8;
   localparam int RA_LSB  = 4;
   localparam int RB_LSB  = 0;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_LATCH,
      S_RD_A,
      S_RD_B,
      S_EXEC,
      S_PUSH,
      S_PUSH_HI,
      S_NEXT,
      S_DONE,
      S_FAULT
   } state_t;

endpackage

// File: rtl/alu_exec_unit.sv
// Combinational opcode/A/B -> result datapath with illegal-opcode flag.
// ALU_EXEC_MUL_EN adds the unsigned double-width multiply (high word on result_hi).
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int OPC_W  = 4
) (
   input  logic [OPC_W-1:0]  opcode,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   output logic [DATA_W-1:0] result,
   output logic [DATA_W-1:0] result_hi,
   output logic              illegal
);

   logic [4:0] shamt;

   assign shamt = op_b[4:0];

   always_comb begin
      result    = '0;
      result_hi = '0;
      illegal   = 1'b0;
      case (opcode)
         OP_NOP: result = '0;
         OP_ADD: result = op_a + op_b;
         OP_SUB: result = op_a - op_b;
         OP_AND: result = op_a & op_b;
         OP_OR:  result = op_a | op_b;
         OP_XOR: result = op_a ^ op_b;
         OP_NOT: result = ~op_a;
         OP_SLL: result = op_a << shamt;
         OP_SRL: result = op_a >> shamt;
         OP_SRA: result = $signed(op_a) >>> shamt;
`ifdef ALU_EXEC_MUL_EN
         OP_MUL: {result_hi, result} = {{DATA_W{1'b0}}, op_a} * {{DATA_W{1'b0}}, op_b};
`endif
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execution controller: drains the instruction FIFO, reads operands from the
// register file and pushes results in order. ALU_EXEC_MUL_EN enables opcode A.
module alu_exec_ctrl
   import alu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int RF_AW  = 4,
   parameter int OPC_W  = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              op_start,
   input  logic              opdone_clear,
   input  logic              inst_empty,
   output logic              inst_rd_en,
   input  logic [DATA_W-1:0] inst_data,
   output logic [RF_AW-1:0]  rf_rAddr,
   input  logic [DATA_W-1:0] rf_rData,
   input  logic              res_full,
   output logic              res_wr_en,
   output logic [DATA_W-1:0] res_data,
   output logic [1:0]        status
);

   localparam int INST_USED = OPC_LSB + OPC_W;

   state_t state, state_nxt;

   logic [INST_USED-1:0] inst_q;
   logic [DATA_W-1:0]    op_a;
   logic [DATA_W-1:0]    op_b;
   logic [DATA_W-1:0]    res_q;
   logic [OPC_W-1:0]     opc_q;
   logic [OPC_W-1:0]     exec_opc;
   logic [DATA_W-1:0]    exec_res;
   logic [DATA_W-1:0]    exec_hi;
   logic                 exec_illegal;
   logic                 unused_inst_hi;

   assign unused_inst_hi = ^inst_data[DATA_W-1:INST_USED];
   assign opc_q          = inst_q[OPC_LSB +: OPC_W];

   // The illegal check happens in LATCH, before inst_q holds the new word.
   assign exec_opc = (state == S_LATCH) ? inst_data[OPC_LSB +: OPC_W] : opc_q;

   alu_exec_unit #(
      .DATA_W (DATA_W),
      .OPC_W  (OPC_W)
   ) u_exec (
      .opcode    (exec_opc),
      .op_a      (op_a),
      .op_b      (op_b),
      .result    (exec_res),
      .result_hi (exec_hi),
      .illegal   (exec_illegal)
   );

`ifdef ALU_EXEC_MUL_EN
   logic [DATA_W-1:0] res_hi;
`else
   logic unused_exec_hi;
   assign unused_exec_hi = ^exec_hi;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (op_start) begin
               state_nxt = inst_empty ? S_DONE : S_FETCH;
            end
         end
         S_FETCH: state_nxt = S_LATCH;
         S_LATCH: state_nxt = exec_illegal ? S_FAULT : S_RD_A;
         S_RD_A:  state_nxt = S_RD_B;
         S_RD_B:  state_nxt = S_EXEC;
         S_EXEC:  state_nxt = (opc_q == OP_NOP) ? S_NEXT : S_PUSH;
         S_PUSH: begin
            if (!res_full) begin
`ifdef ALU_EXEC_MUL_EN
               state_nxt = (opc_q == OP_MUL) ? S_PUSH_HI : S_NEXT;
`else
               state_nxt = S_NEXT;
`endif
            end
         end
`ifdef ALU_EXEC_MUL_EN
         S_PUSH_HI: begin
            if (!res_full) begin
               state_nxt = S_NEXT;
            end
         end
`endif
         S_NEXT: state_nxt = inst_empty ? S_DONE : S_FETCH;
         S_DONE, S_FAULT: begin
            if (opdone_clear) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Operand, instruction and result registers; res_q is held across stalls.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         inst_q <= '0;
         op_a   <= '0;
         op_b   <= '0;
         res_q  <= '0;
`ifdef ALU_EXEC_MUL_EN
         res_hi <= '0;
`endif
      end else begin
         case (state)
            S_LATCH: inst_q <= inst_data[INST_USED-1:0];
            S_RD_A:  op_a   <= rf_rData;
            S_RD_B:  op_b   <= rf_rData;
            S_EXEC: begin
               res_q <= exec_res;
`ifdef ALU_EXEC_MUL_EN
               res_hi <= exec_hi;
`endif
            end
`ifdef ALU_EXEC_MUL_EN
            S_PUSH: begin
               if (!res_full && opc_q == OP_MUL) begin
                  res_q <= res_hi;
               end
            end
`endif
            default: ;
         endcase
      end
   end

   always_comb begin
      rf_rAddr = '0;
      case (state)
         S_RD_A:  rf_rAddr = inst_q[RA_LSB +: RF_AW];
         S_RD_B:  rf_rAddr = inst_q[RB_LSB +: RF_AW];
         default: rf_rAddr = '0;
      endcase
   end

   always_comb begin
      status = ST_EXEC;
      case (state)
         S_IDLE:  status = ST_IDLE;
         S_DONE:  status = ST_DONE;
         S_FAULT: status = ST_FAULT;
         default: status = ST_EXEC;
      endcase
   end

   assign inst_rd_en = (state == S_FETCH);
   assign res_wr_en  = ((state == S_PUSH) || (state == S_PUSH_HI)) && !res_full;
   assign res_data   = res_q;

endmodule
